// File: rtl/rotation_path_ctrl_if.sv
// Handshake/bus bundle between the register file, encoder and the
// steering rotation controller. master drives commands, slave is the controller.
interface rotation_path_ctrl_if #(
    parameter int ANGLE_W = 12,
    parameter int PWM_W   = 8
);
    logic               enable;
    logic               start;
    logic [ANGLE_W-1:0] target_angle;
    logic [ANGLE_W-1:0] current_angle;
    logic               angle_valid;
    logic [PWM_W-1:0]   pwm_duty;
    logic               dir;
    logic               busy;
    logic               done;
    logic               fault;
    logic [ANGLE_W-1:0] err_mag;

    modport master (
        output enable, start, target_angle, current_angle, angle_valid,
        input  pwm_duty, dir, busy, done, fault, err_mag
    );

    modport slave (
        input  enable, start, target_angle, current_angle, angle_valid,
        output pwm_duty, dir, busy, done, fault, err_mag
    );
endinterface

// File: rtl/rotation_path_ctrl.sv
// Closed-loop steering rotation controller: shortest modular path,
// duty ramp/taper, tolerance stop, re-targeting and move timeout.
module rotation_path_ctrl #(
    parameter int ANGLE_W   = 12,
    parameter int PWM_W     = 8,
    parameter int TOL       = 8,
    parameter int SLOW_ZONE = 256,
    parameter int MIN_PWM   = 20,
    parameter int MAX_PWM   = 200,
    parameter int RAMP_STEP = 4,
    parameter int RAMP_DIV  = 1000,
    parameter int TIMEOUT   = 50000000
) (
    input logic           clk,
    input logic           reset_n,
    rotation_path_ctrl_if.slave bus
);

    localparam int DIV_W = $clog2(RAMP_DIV + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [ANGLE_W-1:0] LP_HALF = {1'b1, {(ANGLE_W-1){1'b0}}};
    localparam logic [ANGLE_W-1:0] LP_TOL  = ANGLE_W'(TOL);
    localparam logic [ANGLE_W-1:0] LP_SLOW = ANGLE_W'(SLOW_ZONE);

    localparam logic [PWM_W-1:0] LP_MIN   = PWM_W'(MIN_PWM);
    localparam logic [PWM_W-1:0] LP_MAX   = PWM_W'(MAX_PWM);
    localparam logic [PWM_W:0]   LP_MIN_X = {1'b0, LP_MIN};
    localparam logic [PWM_W:0]   LP_MAX_X = {1'b0, LP_MAX};
    localparam logic [PWM_W:0]   LP_STEP  = (PWM_W+1)'(RAMP_STEP);

    localparam logic [DIV_W-1:0] LP_DIV_END = DIV_W'(RAMP_DIV - 1);
    localparam logic [TO_W-1:0]  LP_TO_END  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_RAMP,
        S_TAPER,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             r_state;
    logic [ANGLE_W-1:0] r_tgt;
    logic [ANGLE_W-1:0] r_err;
    logic [PWM_W-1:0]   r_duty;
    logic               r_dir;
    logic               r_busy;
    logic               r_done;
    logic               r_fault;
    logic               r_rev;
    logic               r_rev_dir;
    logic [DIV_W-1:0]   r_ramp_cnt;
    logic [TO_W-1:0]    r_to_cnt;

    logic [ANGLE_W-1:0] w_d;
    logic               w_dir;
    logic [ANGLE_W-1:0] w_err;
    logic [ANGLE_W-1:0] w_err_cur;
    logic [PWM_W:0]     w_up;
    logic [PWM_W:0]     w_dn;
    logic [PWM_W-1:0]   w_duty_up;
    logic [PWM_W-1:0]   w_duty_dn;
    logic               w_tick;

    // Shortest modular path; an exact half-circle resolves to CW.
    always_comb begin
        w_d       = r_tgt - bus.current_angle;
        w_dir     = (w_d > LP_HALF);
        w_err     = w_dir ? -w_d : w_d;
        w_err_cur = bus.angle_valid ? w_err : r_err;
    end

    // Duty ramp arithmetic with one guard bit, then clamp to the band.
    always_comb begin
        w_up      = {1'b0, r_duty} + LP_STEP;
        w_dn      = {1'b0, r_duty} - LP_STEP;
        w_duty_up = (w_up > LP_MAX_X) ? LP_MAX : w_up[PWM_W-1:0];
        w_duty_dn = (w_dn[PWM_W] || (w_dn < LP_MIN_X)) ?
                    LP_MIN : w_dn[PWM_W-1:0];
        w_tick    = (r_ramp_cnt == LP_DIV_END);
    end

    // Move sequencer: enable and start take priority over timeout,
    // which takes priority over normal tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_tgt      <= '0;
            r_err      <= '0;
            r_duty     <= '0;
            r_dir      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_rev      <= 1'b0;
            r_rev_dir  <= 1'b0;
            r_ramp_cnt <= '0;
            r_to_cnt   <= '0;
        end else if (!bus.enable) begin
            r_state    <= S_IDLE;
            r_duty     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rev      <= 1'b0;
            r_ramp_cnt <= '0;
            r_to_cnt   <= '0;
        end else if (bus.start) begin
            // Duty is held until the new target has been evaluated.
            r_state  <= S_CALC;
            r_tgt    <= bus.target_angle;
            r_fault  <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
            r_rev    <= 1'b0;
            r_to_cnt <= '0;
        end else if (r_busy && (r_to_cnt == LP_TO_END)) begin
            r_state <= S_FAULT;
            r_duty  <= '0;
            r_fault <= 1'b1;
            r_busy  <= 1'b0;
            r_rev   <= 1'b0;
        end else begin
            if (r_busy) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_busy && bus.angle_valid) begin
                r_err <= w_err;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_duty <= '0;
                    r_done <= 1'b0;
                end
                S_CALC: begin
                    if (bus.angle_valid) begin
                        r_dir <= w_dir;
                        if (w_err <= LP_TOL) begin
                            r_state <= S_DONE;
                            r_duty  <= '0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_RAMP;
                            r_duty     <= LP_MIN;
                            r_ramp_cnt <= '0;
                        end
                    end
                end
                S_RAMP, S_TAPER: begin
                    if (r_rev) begin
                        // Second half of a reversal: flip the pin, restart low.
                        r_rev      <= 1'b0;
                        r_dir      <= r_rev_dir;
                        r_duty     <= LP_MIN;
                        r_ramp_cnt <= '0;
                        r_state    <= (w_err_cur <= LP_SLOW) ? S_TAPER : S_RAMP;
                    end else if (bus.angle_valid && (w_err <= LP_TOL)) begin
                        r_state <= S_DONE;
                        r_duty  <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (bus.angle_valid && (w_dir != r_dir)) begin
                        // Coast one cycle before driving the other way.
                        r_duty    <= '0;
                        r_rev     <= 1'b1;
                        r_rev_dir <= w_dir;
                    end else begin
                        if (bus.angle_valid) begin
                            r_state <= (w_err <= LP_SLOW) ? S_TAPER : S_RAMP;
                        end
                        if (w_tick) begin
                            r_ramp_cnt <= '0;
                            r_duty <= (r_state == S_RAMP) ? w_duty_up : w_duty_dn;
                        end else begin
                            r_ramp_cnt <= r_ramp_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pwm_duty = r_duty;
    assign bus.dir      = r_dir;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.fault    = r_fault;
    assign bus.err_mag  = r_err;

endmodule

// File: tb/tb_rotation_path_ctrl.sv
// Directed bench for rotation_path_ctrl: path math, ramp/taper,
// reversal, re-target, timeout, enable and async reset.
module tb_rotation_path_ctrl;

    localparam int RDIV = 100;
    localparam int TOUT = 10000;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    rotation_path_ctrl_if #(.ANGLE_W(12), .PWM_W(8)) bus ();

    rotation_path_ctrl #(
        .RAMP_DIV (RDIV),
        .TIMEOUT  (TOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] tgt);
        bus.target_angle = tgt;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic sample(input logic [11:0] cur);
        bus.current_angle = cur;
        bus.angle_valid = 1'b1;
        step(1);
        bus.angle_valid = 1'b0;
    endtask

    task automatic abort_move();
        bus.enable = 1'b0;
        step(1);
        bus.enable = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (bus.pwm_duty !== 8'd0) begin n_fail++; $display("FAIL rst_duty: got %0d want 0", bus.pwm_duty); end
        n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL rst_dir: got %0b want 0", bus.dir); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", bus.done); end
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %0b want 0", bus.fault); end
        n_tests++; if (bus.err_mag !== 12'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", bus.err_mag); end
        step(2);
        release_reset();
    endtask

    task automatic test_basic();
        do_start(12'd20);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", bus.busy); end
        sample(12'd10);
        n_tests++; if (bus.err_mag !== 12'd10) begin n_fail++; $display("FAIL basic_err: got %0d want 10", bus.err_mag); end
        n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL basic_dir: got %0b want 0", bus.dir); end
        n_tests++; if (bus.pwm_duty !== 8'd20) begin n_fail++; $display("FAIL basic_duty: got %0d want 20", bus.pwm_duty); end
        sample(12'd14);
        n_tests++; if (bus.err_mag !== 12'd6) begin n_fail++; $display("FAIL basic_err2: got %0d want 6", bus.err_mag); end
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b want 1", bus.done); end
        n_tests++; if (bus.pwm_duty !== 8'd0) begin n_fail++; $display("FAIL basic_stop: got %0d want 0", bus.pwm_duty); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %0b want 0", bus.busy); end
        step(1);
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %0b want 0", bus.done); end
    endtask

    task automatic test_tolerance_edge();
        do_start(12'd10);
        sample(12'd2);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL tol8_done: got %0b want 1", bus.done); end
        n_tests++; if (bus.pwm_duty !== 8'd0) begin n_fail++; $display("FAIL tol8_duty: got %0d want 0", bus.pwm_duty); end
        n_tests++; if (bus.err_mag !== 12'd8) begin n_fail++; $display("FAIL tol8_err: got %0d want 8", bus.err_mag); end
        step(1);
        do_start(12'd10);
        sample(12'd1);
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL tol9_done: got %0b want 0", bus.done); end
        n_tests++; if (bus.pwm_duty !== 8'd20) begin n_fail++; $display("FAIL tol9_duty: got %0d want 20", bus.pwm_duty); end
        abort_move();
    endtask

    task automatic test_wrap();
        do_start(12'd10);
        sample(12'd4086);
        n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL wrap_cw_dir: got %0b want 0", bus.dir); end
        n_tests++; if (bus.err_mag !== 12'd20) begin n_fail++; $display("FAIL wrap_cw_err: got %0d want 20", bus.err_mag); end
        abort_move();
        n_tests++; if (bus.pwm_duty !== 8'd0) begin n_fail++; $display("FAIL en_duty: got %0d want 0", bus.pwm_duty); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL en_busy: got %0b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL en_done: got %0b want 0", bus.done); end
        do_start(12'd4086);
        sample(12'd10);
        n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL wrap_ccw_dir: got %0b want 1", bus.dir); end
        n_tests++; if (bus.err_mag !== 12'd20) begin n_fail++; $display("FAIL wrap_ccw_err: got %0d want 20", bus.err_mag); end
        abort_move();
    endtask

    task automatic test_ramp();
        do_start(12'd2048);
        sample(12'd0);
        n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL tie_dir: got %0b want 0", bus.dir); end
        n_tests++; if (bus.err_mag !== 12'd2048) begin n_fail++; $display("FAIL tie_err: got %0d want 2048", bus.err_mag); end
        step(RDIV - 1);
        n_tests++; if (bus.pwm_duty !== 8'd20) begin n_fail++; $display("FAIL ramp_hold: got %0d want 20", bus.pwm_duty); end
        step(1);
        n_tests++; if (bus.pwm_duty !== 8'd24) begin n_fail++; $display("FAIL ramp_24: got %0d want 24", bus.pwm_duty); end
        step(RDIV);
        n_tests++; if (bus.pwm_duty !== 8'd28) begin n_fail++; $display("FAIL ramp_28: got %0d want 28", bus.pwm_duty); end
        step(23 * RDIV);
        n_tests++; if (bus.pwm_duty !== 8'd120) begin n_fail++; $display("FAIL ramp_120: got %0d want 120", bus.pwm_duty); end
        step(20 * RDIV);
        n_tests++; if (bus.pwm_duty !== 8'd200) begin n_fail++; $display("FAIL ramp_200: got %0d want 200", bus.pwm_duty); end
        step(RDIV);
        n_tests++; if (bus.pwm_duty !== 8'd200) begin n_fail++; $display("FAIL ramp_sat: got %0d want 200", bus.pwm_duty); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.pwm_duty !== 8'd0) begin n_fail++; $display("FAIL arst_duty: got %0d want 0", bus.pwm_duty); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %0b want 0", bus.busy); end
        n_tests++; if (bus.err_mag !== 12'd0) begin n_fail++; $display("FAIL arst_err: got %0d want 0", bus.err_mag); end
        release_reset();
    endtask

    task automatic test_async_reset_dir();
        do_start(12'd10);
        sample(12'd20);
        n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL arst_pre_dir: got %0b want 1", bus.dir); end
        step(RDIV);
        n_tests++; if (bus.pwm_duty !== 8'd24) begin n_fail++; $display("FAIL arst_pre_duty: got %0d want 24", bus.pwm_duty); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL arst_dir: got %0b want 0", bus.dir); end
        n_tests++; if (bus.pwm_duty !== 8'd0) begin n_fail++; $display("FAIL arst_duty2: got %0d want 0", bus.pwm_duty); end
        release_reset();
    endtask

    task automatic test_overshoot();
        do_start(12'd1000);
        sample(12'd600);
        n_tests++; if (bus.err_mag !== 12'd400) begin n_fail++; $display("FAIL ov_err: got %0d want 400", bus.err_mag); end
        step(2 * RDIV);
        n_tests++; if (bus.pwm_duty !== 8'd28) begin n_fail++; $display("FAIL ov_ramp: got %0d want 28", bus.pwm_duty); end
        sample(12'd980);
        step(RDIV - 1);
        n_tests++; if (bus.pwm_duty !== 8'd24) begin n_fail++; $display("FAIL taper_24: got %0d want 24", bus.pwm_duty); end
        sample(12'd1030);
        n_tests++; if (bus.pwm_duty !== 8'd0) begin n_fail++; $display("FAIL rev_gap: got %0d want 0", bus.pwm_duty); end
        n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL rev_olddir: got %0b want 0", bus.dir); end
        n_tests++; if (bus.err_mag !== 12'd30) begin n_fail++; $display("FAIL rev_err: got %0d want 30", bus.err_mag); end
        step(1);
        n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL rev_dir: got %0b want 1", bus.dir); end
        n_tests++; if (bus.pwm_duty !== 8'd20) begin n_fail++; $display("FAIL rev_duty: got %0d want 20", bus.pwm_duty); end
        step(RDIV);
        n_tests++; if (bus.pwm_duty !== 8'd20) begin n_fail++; $display("FAIL taper_floor: got %0d want 20", bus.pwm_duty); end
        sample(12'd1004);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ov_done: got %0b want 1", bus.done); end
        n_tests++; if (bus.err_mag !== 12'd4) begin n_fail++; $display("FAIL ov_err2: got %0d want 4", bus.err_mag); end
        step(1);
    endtask

    task automatic test_retarget();
        do_start(12'd2048);
        sample(12'd0);
        step(RDIV);
        do_start(12'd100);
        n_tests++; if (bus.pwm_duty !== 8'd24) begin n_fail++; $display("FAIL rt_hold: got %0d want 24", bus.pwm_duty); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rt_busy: got %0b want 1", bus.busy); end
        sample(12'd0);
        n_tests++; if (bus.err_mag !== 12'd100) begin n_fail++; $display("FAIL rt_err: got %0d want 100", bus.err_mag); end
        n_tests++; if (bus.pwm_duty !== 8'd20) begin n_fail++; $display("FAIL rt_duty: got %0d want 20", bus.pwm_duty); end
        sample(12'd95);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rt_done: got %0b want 1", bus.done); end
        step(1);
    endtask

    task automatic test_timeout();
        int n;
        do_start(12'd600);
        sample(12'd100);
        n_tests++; if (bus.err_mag !== 12'd500) begin n_fail++; $display("FAIL to_err: got %0d want 500", bus.err_mag); end
        n = 1;
        while (bus.fault !== 1'b1 && n < TOUT + 2000) begin
            step(1);
            n++;
        end
        n_tests++; if (n !== TOUT) begin n_fail++; $display("FAIL to_cycle: got %0d want %0d", n, TOUT); end
        n_tests++; if (bus.pwm_duty !== 8'd0) begin n_fail++; $display("FAIL to_duty: got %0d want 0", bus.pwm_duty); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %0b want 0", bus.busy); end
        abort_move();
        step(3);
        n_tests++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %0b want 1", bus.fault); end
        do_start(12'd20);
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %0b want 0", bus.fault); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL to_restart: got %0b want 1", bus.busy); end
        abort_move();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset_n = 1'b0;
        bus.enable = 1'b1;
        bus.start = 1'b0;
        bus.target_angle = '0;
        bus.current_angle = '0;
        bus.angle_valid = 1'b0;
        test_reset();
        test_basic();
        test_tolerance_edge();
        test_wrap();
        test_ramp();
        test_async_reset_dir();
        test_overshoot();
        test_retarget();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
